// File: rtl/strobe_period_meter_pkg.sv
// Shared types for the strobe period meter: FSM state encoding.
package strobe_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_TIMEOUT = 2'd3
    } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and emits a registered one-cycle pulse on its rising edge.
// rise_o goes high SYNC_STAGES+1 edges after d_i is first sampled high; rst wipes all history.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;
    logic                   rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], d_i};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
            rise_q     <= sync_q[SYNC_STAGES-1] & ~sync_dly_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/strobe_period_meter.sv
// Measures rising-edge spacing of an asynchronous strobe: period, block average, lock and stall timeout.
// period_valid lands SYNC_STAGES+2 cycles after the strobe is first sampled high; no backpressure.
module strobe_period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100_000_000,
    parameter int AVG_LOG2    = 2,
    parameter int TOLERANCE   = 1,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             strobe_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic [WIDTH-1:0] avg_period,
    output logic             avg_valid,
    output logic             locked,
    output logic             timeout
);
    import strobe_period_meter_pkg::*;

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int BLK_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int STB_W = $clog2(LOCK_COUNT + 1);

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic             av_q, av_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic             prev_vld_q, prev_vld_d;

    logic             clr;
    logic             rise;
    logic [ACC_W-1:0] acc_sum;
    logic [WIDTH-1:0] abs_diff;
    logic             stable_ok;
    logic             blk_last;

    assign clr = rst | ~enable;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (clr),
        .d_i    (strobe_in),
        .rise_o (rise)
    );

    // period_q doubles as the previous period for the lock comparison.
    assign acc_sum   = acc_q + ACC_W'(cnt_q);
    assign abs_diff  = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    assign stable_ok = prev_vld_q && (abs_diff <= WIDTH'(TOLERANCE));
    assign blk_last  = (blk_q == BLK_W'((1 << AVG_LOG2) - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        pv_d       = 1'b0;
        avg_d      = avg_q;
        av_d       = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        acc_d      = acc_q;
        blk_d      = blk_q;
        stable_d   = stable_q;
        prev_vld_d = prev_vld_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
                if (rise) begin
                    cnt_d   = WIDTH'(1);
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    period_d   = cnt_q;
                    pv_d       = 1'b1;
                    cnt_d      = WIDTH'(1);
                    prev_vld_d = 1'b1;
                    if (blk_last) begin
                        avg_d = WIDTH'(acc_sum >> AVG_LOG2);
                        av_d  = 1'b1;
                        acc_d = '0;
                        blk_d = '0;
                    end else begin
                        acc_d = acc_sum;
                        blk_d = blk_q + BLK_W'(1);
                    end
                    if (!stable_ok)
                        stable_d = '0;
                    else if (stable_q != STB_W'(LOCK_COUNT))
                        stable_d = stable_q + STB_W'(1);
                    locked_d = (stable_d == STB_W'(LOCK_COUNT));
                end else if (cnt_q == WIDTH'(TIMEOUT)) begin
                    state_d    = ST_TIMEOUT;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    period_d   = '0;
                    acc_d      = '0;
                    blk_d      = '0;
                    stable_d   = '0;
                    prev_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            ST_TIMEOUT: begin
                if (rise) begin
                    timeout_d = 1'b0;
                    cnt_d     = WIDTH'(1);
                    state_d   = ST_MEASURE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            avg_q      <= '0;
            av_q       <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            acc_q      <= '0;
            blk_q      <= '0;
            stable_q   <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pv_q       <= pv_d;
            avg_q      <= avg_d;
            av_q       <= av_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            acc_q      <= acc_d;
            blk_q      <= blk_d;
            stable_q   <= stable_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign avg_period   = avg_q;
    assign avg_valid    = av_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Bench for strobe_period_meter: directed scenarios plus random strobe streams against a timestamp-based model.
module tb_strobe_period_meter;
    localparam int W    = 16;
    localparam int SS   = 2;
    localparam int TMO  = 50;
    localparam int AL   = 2;
    localparam int TOL  = 1;
    localparam int LC   = 4;
    localparam int MAXC = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         strobe_in = 1'b0;
    logic [W-1:0] period, avg_period;
    logic         period_valid, avg_valid, locked, timeout;

    always #5 clk = ~clk;

    strobe_period_meter #(
        .WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TMO),
        .AVG_LOG2(AL), .TOLERANCE(TOL), .LOCK_COUNT(LC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .strobe_in(strobe_in),
        .period(period), .period_valid(period_valid),
        .avg_period(avg_period), .avg_valid(avg_valid),
        .locked(locked), .timeout(timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: edges are timestamps; the synchronizer is a pure delay line of sampled values.
    bit   samp [0:MAXC-1];
    int   cyc = 0;
    int   last_edge = -1;
    bit   to_flag = 0;
    int   blk[$];
    int   win[$];
    int   m_period = 0, m_avg = 0;
    bit   m_pv = 0, m_av = 0, m_locked = 0, m_to = 0;

    function automatic void model(input bit en, input bit stb, input bit r);
        bit rise;
        int p, s, d;
        m_pv = 0;
        m_av = 0;
        if (r || !en) begin
            for (int i = cyc - SS - 1; i <= cyc; i++)
                if (i >= 0 && i < MAXC) samp[i] = 0;
            last_edge = -1; to_flag = 0;
            blk.delete(); win.delete();
            m_period = 0; m_avg = 0; m_locked = 0; m_to = 0;
        end else begin
            if (cyc < MAXC) samp[cyc] = stb;
            rise = (cyc >= SS + 2) && (cyc < MAXC) && samp[cyc-SS-1] && !samp[cyc-SS-2];
            if (rise) begin
                if (last_edge >= 0 && !to_flag) begin
                    p = cyc - last_edge;
                    m_period = p;
                    m_pv = 1;
                    blk.push_back(p);
                    if (blk.size() == (1 << AL)) begin
                        s = 0;
                        foreach (blk[i]) s += blk[i];
                        m_avg = s >> AL;
                        m_av = 1;
                        blk.delete();
                    end
                    win.push_back(p);
                    if (win.size() > LC + 1) void'(win.pop_front());
                    m_locked = (win.size() == LC + 1);
                    for (int i = 1; i < win.size(); i++) begin
                        d = win[i] - win[i-1];
                        if (d < 0) d = -d;
                        if (d > TOL) m_locked = 0;
                    end
                end
                last_edge = cyc;
                to_flag = 0;
                m_to = 0;
            end else if (last_edge >= 0 && !to_flag && (cyc - last_edge) == TMO) begin
                to_flag = 1; m_to = 1; m_period = 0; m_locked = 0;
                blk.delete(); win.delete();
            end
        end
        cyc++;
    endfunction

    int pv_seen = 0, lock_at = 0, unlock_at = 0, to_seen = 0;
    int last_pv_cyc = 0, to_rise_cyc = 0, period_at_to = -1;
    bit prev_locked = 0, prev_to = 0;
    int avg_log[$];

    task automatic step(input bit en, input bit stb, input bit r);
        rst = r;
        enable = en;
        strobe_in = stb;
        @(posedge clk);
        model(en, stb, r);
        @(negedge clk);
        chk("period",       period,       m_period);
        chk("period_valid", period_valid, m_pv);
        chk("avg_period",   avg_period,   m_avg);
        chk("avg_valid",    avg_valid,    m_av);
        chk("locked",       locked,       m_locked);
        chk("timeout",      timeout,      m_to);
        if (period_valid === 1'b1) begin pv_seen++; last_pv_cyc = cyc; end
        if (avg_valid === 1'b1) avg_log.push_back(int'(avg_period));
        if (locked === 1'b1 && !prev_locked && lock_at == 0) lock_at = pv_seen;
        if (locked === 1'b0 && prev_locked && unlock_at == 0) unlock_at = pv_seen;
        if (timeout === 1'b1 && !prev_to) begin to_seen++; to_rise_cyc = cyc; period_at_to = int'(period); end
        prev_locked = (locked === 1'b1);
        prev_to = (timeout === 1'b1);
    endtask

    // Strobe high for w cycles then low: the next rising edge is n cycles after this one.
    task automatic pulse(input int n, input int w);
        for (int i = 0; i < n; i++) step(1'b1, i < w, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_pv"}, period_valid, 0);
        chk({tag, "_avg"}, avg_period, 0);
        chk({tag, "_av"}, avg_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int pv0, to0, base, r, n;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_zero("reset");

        // Steady 4-cycle stream, then a single 7-cycle gap.
        for (int i = 0; i < 12; i++) pulse(4, 1);
        chk("t1_pv_count", pv_seen, 11);
        chk("t1_avg_count", avg_log.size(), 2);
        chk("t1_avg_value", (avg_log.size() > 0) ? avg_log[0] : -1, 4);
        chk("t2_lock_at", lock_at, 5);
        chk("t2_locked_held", locked, 1);
        pulse(7, 1);
        for (int i = 0; i < 3; i++) pulse(4, 1);
        chk("t2_unlock_at", unlock_at, 13);

        // Stalled strobe after 10-cycle periods.
        for (int i = 0; i < 3; i++) pulse(10, 2);
        idle(60);
        chk("t3_timeout_seen", to_seen, 1);
        chk("t3_timeout_delay", to_rise_cyc - last_pv_cyc, TMO);
        chk("t3_period_zero", period_at_to, 0);
        pv0 = pv_seen;
        for (int i = 0; i < 3; i++) pulse(6, 2);
        idle(5);
        chk("t3_recover_pv", pv_seen - pv0, 2);
        chk("t3_timeout_clr", timeout, 0);

        // Averaging and truncation after a one-cycle disable.
        step(1'b0, 1'b0, 1'b0);
        chk_zero("t4_dis");
        avg_log.delete();
        pulse(3, 1); pulse(5, 1); pulse(3, 1); pulse(5, 1);
        pulse(3, 1); pulse(3, 1); pulse(3, 1); pulse(4, 1); pulse(5, 1);
        chk("t4_avg_count", avg_log.size(), 2);
        chk("t4_avg_alt", (avg_log.size() > 0) ? avg_log[0] : -1, 4);
        chk("t4_avg_trunc", (avg_log.size() > 1) ? avg_log[1] : -1, 3);

        // Edge exactly at the timeout count.
        to0 = to_seen;
        for (int i = 0; i < 3; i++) pulse(TMO, 1);
        pulse(4, 1);
        idle(5);
        chk("t5_no_timeout", to_seen - to0, 0);
        chk("t5_period", period, TMO);

        // Reset and disable in the middle of a period.
        pulse(4, 1); pulse(4, 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_zero("t6_rst");
        pv0 = pv_seen;
        for (int i = 0; i < 4; i++) pulse(4, 1);
        idle(3);
        chk("t6_rst_pv", pv_seen - pv0, 3);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_zero("t6_dis");
        pv0 = pv_seen;
        for (int i = 0; i < 4; i++) pulse(4, 1);
        idle(3);
        chk("t6_dis_pv", pv_seen - pv0, 3);

        // Random streams with jitter, long gaps, disables and resets.
        base = 8;
        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                step(1'b0, 1'b0, 1'b0);
                if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0);
            end else if (r < 5) begin
                step(1'b1, 1'b0, 1'b1);
            end else begin
                if (r < 12) begin
                    n = int'($urandom_range(45, 60));
                end else begin
                    if ($urandom_range(0, 9) == 0) base = int'($urandom_range(2, 30));
                    n = base + int'($urandom_range(0, 2)) - 1;
                    if (n < 2) n = 2;
                end
                pulse(n, int'($urandom_range(1, n - 1)));
            end
        end
        idle(70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
